// File: rtl/slv_guard_rst_ctrl.sv
// ---------------------------------------------------------------------------
// slv_guard_rst_ctrl
//
// Recovery sequencer that sits directly after slv_guard_top. When the guard
// requests a reset, this block isolates the guarded AXI subordinate through an
// external axi_isolate stage and pulses the subordinate's reset. It then
// clears the guard and removes the isolation. If reset requests keep arriving
// shortly after each recovery, the block stops retrying and parks in a sticky
// FATAL state. A latched interrupt informs the system about each event.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous reset, active-high (held in reset while 1)
//   rst_req_i    reset request from slv_guard_top (level, sampled in IDLE)
//   guard_irq_i  interrupt from slv_guard_top (level)
//   isolated_i   isolate stage reports the subordinate quiescent/isolated
//   irq_ack_i    software acknowledge for irq_o
//   isolate_o    isolation request toward the isolate stage
//   sub_rst_no   subordinate reset, active-low
//   guard_clr_o  one-cycle pulse that clears guard timers/status
//   busy_o       high whenever the sequencer is not idle
//   fatal_o      sticky, high in FATAL
//   iso_to_o     sticky, an isolation timeout has occurred
//   irq_o        latched interrupt
//   rst_count_o  completed subordinate resets, saturating at 255
// ---------------------------------------------------------------------------
module slv_guard_rst_ctrl #(
    parameter int IsoTimeoutCycles = 256,
    parameter int RstPulseCycles   = 16,
    parameter int RetryWindow      = 1024,
    parameter int MaxRetries       = 3,
    parameter int CntWidth         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rst_req_i,
    input  logic       guard_irq_i,
    input  logic       isolated_i,
    input  logic       irq_ack_i,
    output logic       isolate_o,
    output logic       sub_rst_no,
    output logic       guard_clr_o,
    output logic       busy_o,
    output logic       fatal_o,
    output logic       iso_to_o,
    output logic       irq_o,
    output logic [7:0] rst_count_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISOLATE = 3'd1;
    localparam logic [2:0] S_RESET   = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DEISO   = 3'd4;
    localparam logic [2:0] S_FATAL   = 3'd5;

    localparam int RetryW = $clog2(MaxRetries + 1);

    localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);
    localparam logic [CntWidth-1:0] ISO_LAST = CntWidth'(IsoTimeoutCycles - 1);
    localparam logic [CntWidth-1:0] RST_LAST = CntWidth'(RstPulseCycles - 1);
    localparam logic [CntWidth-1:0] WIN_LAST = CntWidth'(RetryWindow - 1);

    localparam logic [RetryW-1:0] RETRY_ONE = RetryW'(1);
    localparam logic [RetryW-1:0] RETRY_MAX = RetryW'(MaxRetries);

    logic [2:0]          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic                win_q, win_d;
    logic                iso_to_set;
    logic                count_inc;
    logic                irq_set;

    // Next-state logic. A single counter is shared by every timed phase:
    // the isolation timeout, the reset pulse, the two release cycles and the
    // retry window in IDLE. Each transition clears it so the next phase
    // always starts counting from zero. Retry accounting happens at the
    // moment a request is accepted in IDLE, so a request that lands while
    // the window is still open counts as a retry and may divert straight
    // into FATAL without touching the subordinate again.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        win_d      = win_q;
        iso_to_set = 1'b0;
        count_inc  = 1'b0;
        irq_set    = guard_irq_i;

        case (state_q)
            S_IDLE: begin
                if (rst_req_i) begin
                    retry_d = win_q ? (retry_q + RETRY_ONE) : RETRY_ONE;
                    cnt_d   = '0;
                    win_d   = 1'b0;
                    irq_set = 1'b1;
                    state_d = (retry_d >= RETRY_MAX) ? S_FATAL : S_ISOLATE;
                end else if (win_q) begin
                    if (cnt_q == WIN_LAST) begin
                        win_d   = 1'b0;
                        retry_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            S_ISOLATE: begin
                if (isolated_i) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end else if (cnt_q == ISO_LAST) begin
                    iso_to_set = 1'b1;
                    state_d    = S_RESET;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d   = S_RELEASE;
                    cnt_d     = '0;
                    count_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_RELEASE: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DEISO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DEISO: begin
                if (!isolated_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    win_d   = 1'b1;
                end
            end

            S_FATAL: begin
                state_d = S_FATAL;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and retry bookkeeping. The reset input is active-high
    // even though it carries the legacy rst_n name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            win_q   <= win_d;
        end
    end

    // Output flops are loaded from the next state, so each output changes on
    // the same edge as the state it belongs to while still coming straight
    // from a register. guard_clr_o is loaded during the first RELEASE cycle
    // so that it is visible during the second one. The async reset drops all
    // of these at once, which releases sub_rst_no immediately.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            isolate_o   <= 1'b0;
            sub_rst_no  <= 1'b1;
            guard_clr_o <= 1'b0;
            busy_o      <= 1'b0;
            fatal_o     <= 1'b0;
        end else begin
            isolate_o   <= (state_d == S_ISOLATE) || (state_d == S_RESET) ||
                           (state_d == S_RELEASE) || (state_d == S_FATAL);
            sub_rst_no  <= !((state_d == S_RESET) || (state_d == S_FATAL));
            guard_clr_o <= (state_q == S_RELEASE) && (cnt_q == '0);
            busy_o      <= (state_d != S_IDLE);
            fatal_o     <= (state_d == S_FATAL);
        end
    end

    // Sticky status and the reset counter. A new interrupt event beats a
    // simultaneous acknowledge so no event is lost. The counter stops at
    // 255 instead of wrapping.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            iso_to_o    <= 1'b0;
            irq_o       <= 1'b0;
            rst_count_o <= 8'd0;
        end else begin
            if (iso_to_set) begin
                iso_to_o <= 1'b1;
            end
            if (irq_set) begin
                irq_o <= 1'b1;
            end else if (irq_ack_i) begin
                irq_o <= 1'b0;
            end
            if (count_inc && (rst_count_o != 8'hFF)) begin
                rst_count_o <= rst_count_o + 8'd1;
            end
        end
    end

endmodule
